// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - 4-digit multiplexed 7-segment driver with frame snapshot
// Digits are snapshotted once per frame so a frame never mixes old and new values.
module seg7_scan_driver #(
  parameter int DIGIT_TICKS      = 100000,
  parameter bit ANODE_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW   = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] bcd3,
  input  logic [3:0] bcd2,
  input  logic [3:0] bcd1,
  input  logic [3:0] bcd0,
  input  logic       blank_lz,
  input  logic [3:0] dp_sel,
  input  logic       enable,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_done
);

  localparam int             PW        = $clog2(DIGIT_TICKS);
  localparam logic [PW-1:0]  LAST_TICK = PW'(DIGIT_TICKS - 1);
  localparam logic [3:0]     AN_OFF    = ANODE_ACTIVE_LOW ? 4'hF : 4'h0;
  localparam logic [6:0]     SEG_OFF   = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic           DP_OFF    = SEG_ACTIVE_LOW;

  logic [PW-1:0]   r_presc;
  logic [1:0]      r_idx;
  logic [3:0][3:0] r_sh_digit;
  logic            r_sh_blz;
  logic [3:0]      r_sh_dp;
  logic            r_load_pend;
  logic [3:0]      r_an;
  logic [6:0]      r_seg;
  logic            r_dp;
  logic            r_frame_done;

  logic            w_tick;
  logic            w_frame_end;
  logic            w_load;
  logic [3:0]      w_digit;
  logic [6:0]      w_glyph;
  logic [3:0]      w_zero_run;
  logic            w_blank;
  logic [3:0]      w_an_next;
  logic [6:0]      w_seg_next;
  logic            w_dp_next;

  assign w_tick      = enable && (r_presc == LAST_TICK);
  assign w_frame_end = w_tick && (r_idx == 2'd3);
  assign w_load      = enable && (r_load_pend || w_frame_end);
  assign w_digit     = r_sh_digit[r_idx];

  always_comb begin
    w_glyph = 7'h40;
    case (w_digit)
      4'd0: w_glyph = 7'h3F;
      4'd1: w_glyph = 7'h06;
      4'd2: w_glyph = 7'h5B;
      4'd3: w_glyph = 7'h4F;
      4'd4: w_glyph = 7'h66;
      4'd5: w_glyph = 7'h6D;
      4'd6: w_glyph = 7'h7D;
      4'd7: w_glyph = 7'h07;
      4'd8: w_glyph = 7'h7F;
      4'd9: w_glyph = 7'h6F;
      default: w_glyph = 7'h40;
    endcase
  end

  // w_zero_run[k]: digits k..3 all zero; bit 0 forced low so the ones digit always shows.
  always_comb begin
    w_zero_run    = 4'b0000;
    w_zero_run[3] = (r_sh_digit[3] == 4'd0);
    w_zero_run[2] = w_zero_run[3] && (r_sh_digit[2] == 4'd0);
    w_zero_run[1] = w_zero_run[2] && (r_sh_digit[1] == 4'd0);
  end

  assign w_blank = r_sh_blz && w_zero_run[r_idx];

  always_comb begin
    w_an_next  = AN_OFF;
    w_seg_next = SEG_OFF;
    w_dp_next  = DP_OFF;
    if (enable) begin
      w_an_next  = (4'b0001 << r_idx) ^ {4{ANODE_ACTIVE_LOW}};
      w_seg_next = (w_blank ? 7'h00 : w_glyph) ^ {7{SEG_ACTIVE_LOW}};
      w_dp_next  = r_sh_dp[r_idx] ^ SEG_ACTIVE_LOW;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_idx   <= 2'd0;
    end else if (enable) begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (w_tick) begin
        r_idx <= r_idx + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sh_digit  <= '0;
      r_sh_blz    <= 1'b0;
      r_sh_dp     <= 4'd0;
      r_load_pend <= 1'b1;
    end else if (w_load) begin
      r_sh_digit  <= {bcd3, bcd2, bcd1, bcd0};
      r_sh_blz    <= blank_lz;
      r_sh_dp     <= dp_sel;
      r_load_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_an         <= AN_OFF;
      r_seg        <= SEG_OFF;
      r_dp         <= DP_OFF;
      r_frame_done <= 1'b0;
    end else begin
      r_an         <= w_an_next;
      r_seg        <= w_seg_next;
      r_dp         <= w_dp_next;
      r_frame_done <= w_frame_end;
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign dp         = r_dp;
  assign frame_done = r_frame_done;

endmodule
